instruction_fetch: RTL and testbench

//  Front end of the RV32I core: holds the PC and fetches one instruction per cycle from imem over a req/ready handshake.

---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/instruction_fetch_branch_target.sv | 50 +++++
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the instruction fetch front end
// Purpose: fetch FSM state encoding, default NOP word, PC increment and word-alignment helper.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_BUSY,
    FETCH_DRAIN
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_INCR           = 32'd4;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instruction_fetch_branch_target.sv
// rtl/instruction_fetch_branch_target.sv - redirect detection and target address computation
// Purpose: decides whether the PC must be redirected and computes the word-aligned target.
// Ports:
//   control_branch, branch_taken  conditional branch and its compare result
//   jal_en, jalr_branch           unconditional jumps
//   branch_pc                     PC of the redirecting instruction
//   imm                           B-type offset[12:1] or I-type immediate
//   imm_U_J                       J-type offset[20:1]
//   rs1_data                      JALR base register
//   redirect                      PC must load target this cycle
//   target                        word-aligned next PC (priority jalr > jal > branch)
module instruction_fetch_branch_target
  import instruction_fetch_pkg::*;
(
  input  logic        control_branch,
  input  logic        branch_taken,
  input  logic        jal_en,
  input  logic        jalr_branch,
  input  logic [31:0] branch_pc,
  input  logic [11:0] imm,
  input  logic [19:0] imm_U_J,
  input  logic [31:0] rs1_data,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] jalr_sum;
  logic [31:0] jal_sum;
  logic [31:0] br_sum;
  logic [31:0] raw_target;

  assign jalr_sum = rs1_data + {{20{imm[11]}}, imm};
  assign jal_sum  = branch_pc + {{11{imm_U_J[19]}}, imm_U_J, 1'b0};
  assign br_sum   = branch_pc + {{19{imm[11]}}, imm, 1'b0};

  assign redirect = jalr_branch | jal_en | (control_branch & branch_taken);

  always_comb begin
    raw_target = br_sum;
    if (jalr_branch) begin
      raw_target = jalr_sum & ~32'h1;
    end else if (jal_en) begin
      raw_target = jal_sum;
    end
  end

  // A misaligned computed target is silently forced onto a word boundary.
  assign target = word_align(raw_target);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I fetch stage: PC, imem handshake and one-entry fetch slot
// Purpose: fetches one instruction per cycle from imem and presents it to the decoder.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   stall                          decoder cannot accept; hold the slot
//   control_branch .. rs1_data     redirect controls and operands
//   imem_req, imem_addr            memory request and word address
//   imem_ready, imem_rdata         memory response
//   instr, instr_pc, instr_valid   fetch slot towards the decoder
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        control_branch,
  input  logic        branch_taken,
  input  logic        jal_en,
  input  logic        jalr_branch,
  input  logic [31:0] branch_pc,
  input  logic [11:0] imm,
  input  logic [19:0] imm_U_J,
  input  logic [31:0] rs1_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         redirect;
  logic [31:0]  target;
  logic         can_issue;

  instruction_fetch_branch_target u_branch_target (
    .control_branch (control_branch),
    .branch_taken   (branch_taken),
    .jal_en         (jal_en),
    .jalr_branch    (jalr_branch),
    .branch_pc      (branch_pc),
    .imm            (imm),
    .imm_U_J        (imm_U_J),
    .rs1_data       (rs1_data),
    .redirect       (redirect),
    .target         (target)
  );

  // The slot is free if empty or being consumed by the decoder this cycle.
  assign can_issue = !instr_valid || !stall;

  // Request is combinational so a zero-latency memory sustains one fetch per cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (reset) begin
      imem_req  = 1'b0;
      imem_addr = RESET_PC;
    end else begin
      case (state)
        FETCH_IDLE: begin
          imem_req  = can_issue && !redirect;
          imem_addr = pc;
        end
        FETCH_BUSY, FETCH_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = req_addr;
        end
        default: begin
          imem_req  = 1'b0;
          imem_addr = pc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH_IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      // Default: the decoder drains the slot; fill or redirect below override this.
      if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end

      if (redirect) begin
        pc          <= target;
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
      end

      case (state)
        FETCH_IDLE: begin
          if (!redirect && imem_req) begin
            if (imem_ready) begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + PC_INCR;
            end else begin
              req_addr <= pc;
              state    <= FETCH_BUSY;
            end
          end
        end
        FETCH_BUSY: begin
          if (redirect) begin
            // The in-flight response belongs to the wrong path and is dropped.
            state <= imem_ready ? FETCH_IDLE : FETCH_DRAIN;
          end else if (imem_ready) begin
            instr       <= imem_rdata;
            instr_pc    <= req_addr;
            instr_valid <= 1'b1;
            pc          <= pc + PC_INCR;
            state       <= FETCH_IDLE;
          end
        end
        FETCH_DRAIN: begin
          if (imem_ready) begin
            state <= FETCH_IDLE;
          end
        end
        default: begin
          state <= FETCH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TAG  = 32'h1000_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        control_branch;
  logic        branch_taken;
  logic        jal_en;
  logic        jalr_branch;
  logic [31:0] branch_pc;
  logic [11:0] imm;
  logic [19:0] imm_U_J;
  logic [31:0] rs1_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        use_junk;

  int checks;
  int passes;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .control_branch (control_branch),
    .branch_taken   (branch_taken),
    .jal_en         (jal_en),
    .jalr_branch    (jalr_branch),
    .branch_pc      (branch_pc),
    .imm            (imm),
    .imm_U_J        (imm_U_J),
    .rs1_data       (rs1_data),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid)
  );

  // Memory model: each word holds its own address tagged, or a junk word.
  assign imem_rdata = use_junk ? JUNK : (imem_addr + TAG);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect;
    control_branch = 1'b0;
    branch_taken   = 1'b0;
    jal_en         = 1'b0;
    jalr_branch    = 1'b0;
    branch_pc      = 32'h0;
    imm            = 12'h0;
    imm_U_J        = 20'h0;
    rs1_data       = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; use_junk = 1'b0;
    clear_redirect();
    tick(); tick();
    checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else passes++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 00000000", imem_addr); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", instr_valid); else passes++;
    checks++; if (instr !== NOP) $display("FAIL rst_instr got %h exp %h", instr, NOP); else passes++;
    checks++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc got %h exp 00000000", instr_pc); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) $display("FAIL rel_req got %b exp 1", imem_req); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rel_valid got %b exp 0", instr_valid); else passes++;
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %b exp 1", i, instr_valid); else passes++;
      checks++; if (instr_pc !== 32'(4 * i)) $display("FAIL seq_pc[%0d] got %h exp %h", i, instr_pc, 32'(4 * i)); else passes++;
      checks++; if (instr !== 32'(4 * i) + TAG) $display("FAIL seq_instr[%0d] got %h exp %h", i, instr, 32'(4 * i) + TAG); else passes++;
      checks++; if (imem_addr !== 32'(4 * i + 4)) $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_addr, 32'(4 * i + 4)); else passes++;
    end
  endtask

  task automatic test_wait_states;
    reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick();
    imem_ready = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h8) $display("FAIL ws_addr0 got %h exp 00000008", imem_addr); else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_req !== 1'b1) $display("FAIL ws_req[%0d] got %b exp 1", i, imem_req); else passes++;
      checks++; if (imem_addr !== 32'h8) $display("FAIL ws_addr[%0d] got %h exp 00000008", i, imem_addr); else passes++;
      checks++; if (instr_valid !== 1'b0) $display("FAIL ws_valid[%0d] got %b exp 0", i, instr_valid); else passes++;
    end
    imem_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b1) $display("FAIL ws_fill_valid got %b exp 1", instr_valid); else passes++;
    checks++; if (instr_pc !== 32'h8) $display("FAIL ws_fill_pc got %h exp 00000008", instr_pc); else passes++;
    checks++; if (instr !== 32'h8 + TAG) $display("FAIL ws_fill_instr got %h exp %h", instr, 32'h8 + TAG); else passes++;
  endtask

  task automatic test_stall;
    stall = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL st_req0 got %b exp 0", imem_req); else passes++;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (instr_pc !== 32'h8) $display("FAIL st_pc[%0d] got %h exp 00000008", i, instr_pc); else passes++;
      checks++; if (instr !== 32'h8 + TAG) $display("FAIL st_instr[%0d] got %h exp %h", i, instr, 32'h8 + TAG); else passes++;
      checks++; if (instr_valid !== 1'b1) $display("FAIL st_valid[%0d] got %b exp 1", i, instr_valid); else passes++;
      checks++; if (imem_req !== 1'b0) $display("FAIL st_req[%0d] got %b exp 0", i, imem_req); else passes++;
      checks++; if (imem_addr !== 32'hC) $display("FAIL st_addr[%0d] got %h exp 0000000c", i, imem_addr); else passes++;
    end
    stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) $display("FAIL st_rel_req got %b exp 1", imem_req); else passes++;
    tick();
    checks++; if (instr_pc !== 32'hC) $display("FAIL st_next_pc got %h exp 0000000c", instr_pc); else passes++;
  endtask

  task automatic test_branch;
    control_branch = 1'b1; branch_taken = 1'b1; branch_pc = 32'h100; imm = 12'h008;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL br_req got %b exp 0", imem_req); else passes++;
    tick();
    clear_redirect();
    #1;
    checks++; if (instr_valid !== 1'b0) $display("FAIL br_flush got %b exp 0", instr_valid); else passes++;
    checks++; if (instr !== NOP) $display("FAIL br_nop got %h exp %h", instr, NOP); else passes++;
    checks++; if (imem_addr !== 32'h110) $display("FAIL br_addr got %h exp 00000110", imem_addr); else passes++;
    checks++; if (imem_req !== 1'b1) $display("FAIL br_req1 got %b exp 1", imem_req); else passes++;
    tick();
    checks++; if (instr_pc !== 32'h110) $display("FAIL br_tgt_pc got %h exp 00000110", instr_pc); else passes++;
    control_branch = 1'b1; branch_taken = 1'b0; branch_pc = 32'h100; imm = 12'h008;
    #1;
    checks++; if (imem_addr !== 32'h114) $display("FAIL nt_addr got %h exp 00000114", imem_addr); else passes++;
    tick();
    checks++; if (instr_pc !== 32'h114) $display("FAIL nt_pc got %h exp 00000114", instr_pc); else passes++;
    checks++; if (instr_valid !== 1'b1) $display("FAIL nt_valid got %b exp 1", instr_valid); else passes++;
    clear_redirect();
  endtask

  task automatic test_jump;
    jalr_branch = 1'b1; rs1_data = 32'h203; imm = 12'hFFF;
    tick(); clear_redirect(); #1;
    checks++; if (imem_addr !== 32'h200) $display("FAIL jalr_addr got %h exp 00000200", imem_addr); else passes++;
    tick();
    checks++; if (instr_pc !== 32'h200) $display("FAIL jalr_pc got %h exp 00000200", instr_pc); else passes++;
    jal_en = 1'b1; branch_pc = 32'h10; imm_U_J = 20'hFFFFE;
    tick(); clear_redirect(); #1;
    checks++; if (imem_addr !== 32'hC) $display("FAIL jal_addr got %h exp 0000000c", imem_addr); else passes++;
    tick();
    checks++; if (instr_pc !== 32'hC) $display("FAIL jal_pc got %h exp 0000000c", instr_pc); else passes++;
    jalr_branch = 1'b1; rs1_data = 32'h203; imm = 12'hFFF;
    jal_en = 1'b1; branch_pc = 32'h10; imm_U_J = 20'hFFFFE;
    tick(); clear_redirect(); #1;
    checks++; if (imem_addr !== 32'h200) $display("FAIL prio_addr got %h exp 00000200", imem_addr); else passes++;
    jalr_branch = 1'b1; rs1_data = 32'hFFFF_FFFC; imm = 12'h000;
    tick(); clear_redirect(); #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got %h exp fffffffc", imem_addr); else passes++;
    tick();
    checks++; if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h exp fffffffc", instr_pc); else passes++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h exp 00000000", imem_addr); else passes++;
  endtask

  task automatic test_redirect_busy;
    imem_ready = 1'b0; use_junk = 1'b1;
    jalr_branch = 1'b1; rs1_data = 32'h200; imm = 12'h000;
    tick(); clear_redirect(); #1;
    checks++; if (imem_addr !== 32'h200) $display("FAIL rb_addr0 got %h exp 00000200", imem_addr); else passes++;
    tick();
    jal_en = 1'b1; branch_pc = 32'h40; imm_U_J = 20'h00010;
    #1;
    checks++; if (imem_req !== 1'b1) $display("FAIL rb_busy_req got %b exp 1", imem_req); else passes++;
    tick(); clear_redirect(); #1;
    checks++; if (imem_addr !== 32'h200) $display("FAIL rb_drain_addr got %h exp 00000200", imem_addr); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rb_drain_valid got %b exp 0", instr_valid); else passes++;
    tick();
    checks++; if (imem_req !== 1'b1) $display("FAIL rb_drain_req got %b exp 1", imem_req); else passes++;
    imem_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0) $display("FAIL rb_discard_valid got %b exp 0", instr_valid); else passes++;
    checks++; if (instr !== NOP) $display("FAIL rb_discard_instr got %h exp %h", instr, NOP); else passes++;
    checks++; if (imem_addr !== 32'h60) $display("FAIL rb_tgt_addr got %h exp 00000060", imem_addr); else passes++;
    use_junk = 1'b0;
    tick();
    checks++; if (instr_pc !== 32'h60) $display("FAIL rb_tgt_pc got %h exp 00000060", instr_pc); else passes++;
    checks++; if (instr !== 32'h60 + TAG) $display("FAIL rb_tgt_instr got %h exp %h", instr, 32'h60 + TAG); else passes++;
  endtask

  task automatic test_reset_busy;
    imem_ready = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h64) $display("FAIL rsb_addr got %h exp 00000064", imem_addr); else passes++;
    reset = 1'b1; imem_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL rsb_req got %b exp 0", imem_req); else passes++;
    tick();
    checks++; if (instr_valid !== 1'b0) $display("FAIL rsb_valid got %b exp 0", instr_valid); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0) $display("FAIL rsb_pc got %h exp 00000000", imem_addr); else passes++;
    checks++; if (imem_req !== 1'b1) $display("FAIL rsb_req1 got %b exp 1", imem_req); else passes++;
    tick();
    checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) $display("FAIL rsb_fill got pc %h v %b exp pc 00000000 v 1", instr_pc, instr_valid); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall();
    test_branch();
    test_jump();
    test_redirect_busy();
    test_reset_busy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
